// File: rtl/spider_controller.sv
// Spider sprite controller: zig-zags across the screen one step per frame, descends on wall bounces, dies on hit.
// Build macro SPIDER_RESPAWN_EN: when defined, DEAD respawns after RESPAWN_FRAMES frames; otherwise DEAD falls back to IDLE.
module spider_controller #(
  parameter int X_MIN          = 0,
  parameter int X_MAX          = 608,
  parameter int Y_START        = 32,
  parameter int Y_MAX          = 448,
  parameter int STEP_X         = 4,
  parameter int STEP_Y         = 16,
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       hit,
  output logic [9:0] spider_x,
  output logic [9:0] spider_y,
  output logic       spider_alive,
  output logic       kill_pulse,
  output logic       bottom_pulse
);

  if (RESPAWN_FRAMES < 1) begin : g_bad_respawn
    $error("RESPAWN_FRAMES must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ALIVE, S_DEAD} state_t;

  state_t     r_state;
  logic       r_dir;  // 0 = moving right, 1 = moving left
  logic [9:0] r_x, r_y;
  logic       r_alive, r_kill, r_bot;

`ifdef SPIDER_RESPAWN_EN
  localparam int CNT_W = $clog2(RESPAWN_FRAMES + 1);
  logic [CNT_W-1:0] r_cnt;
`endif

  logic [10:0] w_x_sum, w_y_sum;
  logic [9:0]  w_x_nxt, w_y_nxt;
  logic        w_dir_nxt, w_descend, w_wrap;

  // Next position for one frame step, all in 11 bits so the wall tests cannot wrap.
  always_comb begin
    w_x_sum   = {1'b0, r_x} + 11'(STEP_X);
    w_y_sum   = {1'b0, r_y} + 11'(STEP_Y);
    w_x_nxt   = r_x;
    w_dir_nxt = r_dir;
    w_descend = 1'b0;
    if (!r_dir) begin
      if (w_x_sum >= 11'(X_MAX)) begin
        w_x_nxt   = 10'(X_MAX);
        w_dir_nxt = 1'b1;
        w_descend = 1'b1;
      end else begin
        w_x_nxt = w_x_sum[9:0];
      end
    end else begin
      if ({1'b0, r_x} <= 11'(X_MIN + STEP_X)) begin
        w_x_nxt   = 10'(X_MIN);
        w_dir_nxt = 1'b0;
        w_descend = 1'b1;
      end else begin
        w_x_nxt = r_x - 10'(STEP_X);
      end
    end
    w_wrap  = w_descend && (w_y_sum > 11'(Y_MAX));
    w_y_nxt = r_y;
    if (w_wrap)         w_y_nxt = 10'(Y_START);
    else if (w_descend) w_y_nxt = w_y_sum[9:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_dir   <= 1'b0;
      r_x     <= 10'(X_MIN);
      r_y     <= 10'(Y_START);
      r_alive <= 1'b0;
      r_kill  <= 1'b0;
      r_bot   <= 1'b0;
`ifdef SPIDER_RESPAWN_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_kill <= 1'b0;
      r_bot  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_ALIVE;
            r_dir   <= 1'b0;
            r_x     <= 10'(X_MIN);
            r_y     <= 10'(Y_START);
            r_alive <= 1'b1;
          end
        end
        S_ALIVE: begin
          // A hit outranks a coincident frame tick: the sprite dies where it stands.
          if (hit) begin
            r_state <= S_DEAD;
            r_alive <= 1'b0;
            r_kill  <= 1'b1;
`ifdef SPIDER_RESPAWN_EN
            r_cnt   <= '0;
`endif
          end else if (frame_tick) begin
            r_x   <= w_x_nxt;
            r_y   <= w_y_nxt;
            r_dir <= w_dir_nxt;
            r_bot <= w_wrap;
          end
        end
        S_DEAD: begin
`ifdef SPIDER_RESPAWN_EN
          if (frame_tick) begin
            if (r_cnt == CNT_W'(RESPAWN_FRAMES - 1)) begin
              r_state <= S_ALIVE;
              r_cnt   <= '0;
              r_dir   <= 1'b0;
              r_x     <= 10'(X_MIN);
              r_y     <= 10'(Y_START);
              r_alive <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
`else
          if (frame_tick) r_state <= S_IDLE;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign spider_x     = r_x;
  assign spider_y     = r_y;
  assign spider_alive = r_alive;
  assign kill_pulse   = r_kill;
  assign bottom_pulse = r_bot;

endmodule

// File: tb/tb_spider_controller.sv
// Self-checking bench for spider_controller: vector table plus long walk, bounce, wrap, kill and reset sequences.
module tb_spider_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0, frame_tick = 1'b0, hit = 1'b0;
  logic [9:0] spider_x, spider_y;
  logic       spider_alive, kill_pulse, bottom_pulse;

  spider_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_tick(frame_tick), .hit(hit),
    .spider_x(spider_x), .spider_y(spider_y), .spider_alive(spider_alive),
    .kill_pulse(kill_pulse), .bottom_pulse(bottom_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       alive;
    logic       kill;
    logic       bot;
  } exp_t;

  typedef struct {
    logic  s, t, h;
    exp_t  e;
    string nm;
  } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic exp_t mk(int x, int y, logic a, logic k, logic b);
    exp_t e;
    e.x = 10'(x); e.y = 10'(y); e.alive = a; e.kill = k; e.bot = b;
    return e;
  endfunction

  task automatic compare(input string nm);
    exp_t e;
    e = sb.pop_front();
    n_vec++;
    if (spider_x !== e.x || spider_y !== e.y || spider_alive !== e.alive ||
        kill_pulse !== e.kill || bottom_pulse !== e.bot) begin
      n_err++;
      $display("FAIL %s: got x=%0d y=%0d alive=%b kill=%b bot=%b, want x=%0d y=%0d alive=%b kill=%b bot=%b",
               nm, spider_x, spider_y, spider_alive, kill_pulse, bottom_pulse,
               e.x, e.y, e.alive, e.kill, e.bot);
    end
  endtask

  // One clock: inputs driven at negedge, expectation queued, outputs sampled 1ns after posedge.
  task automatic cyc(input logic s, input logic t, input logic h,
                     input bit chk, input exp_t e, input string nm);
    @(negedge clk);
    start = s; frame_tick = t; hit = h;
    if (chk) sb.push_back(e);
    @(posedge clk);
    #1;
    if (chk) compare(nm);
  endtask

  task automatic tick(input bit chk, input exp_t e, input string nm);
    cyc(1'b0, 1'b1, 1'b0, chk, e, nm);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, e, "");
  endtask

  vec_t vt[10];
  exp_t none;

  initial begin
    none = mk(0, 32, 1'b0, 1'b0, 1'b0);
    vt[0] = '{1'b0, 1'b0, 1'b1, mk(0, 32, 0, 0, 0), "hit_in_idle"};
    vt[1] = '{1'b0, 1'b1, 1'b0, mk(0, 32, 0, 0, 0), "tick_in_idle"};
    vt[2] = '{1'b1, 1'b0, 1'b0, mk(0, 32, 1, 0, 0), "start"};
    vt[3] = '{1'b0, 1'b0, 1'b0, mk(0, 32, 1, 0, 0), "hold0"};
    vt[4] = '{1'b0, 1'b1, 1'b0, mk(4, 32, 1, 0, 0), "tick1"};
    vt[5] = '{1'b0, 1'b0, 1'b0, mk(4, 32, 1, 0, 0), "hold1"};
    vt[6] = '{1'b1, 1'b0, 1'b0, mk(4, 32, 1, 0, 0), "start_ignored"};
    vt[7] = '{1'b0, 1'b1, 1'b0, mk(8, 32, 1, 0, 0), "tick2"};
    vt[8] = '{1'b0, 1'b1, 1'b0, mk(12, 32, 1, 0, 0), "tick3"};
    vt[9] = '{1'b0, 1'b0, 1'b0, mk(12, 32, 1, 0, 0), "hold3"};

    // Reset asserted before any clock edge.
    #1 rst_n = 1'b0;
    #1 sb.push_back(mk(0, 32, 0, 0, 0));
    compare("reset_state");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      cyc(vt[i].s, vt[i].t, vt[i].h, 1'b1, vt[i].e, vt[i].nm);

    // Walk right to 604, bounce off the right wall, step back.
    for (int k = 1; k <= 148; k++) tick(1'b1, mk(12 + 4 * k, 32, 1, 0, 0), "walk_right");
    tick(1'b1, mk(608, 48, 1, 0, 0), "right_wall");
    tick(1'b1, mk(604, 48, 1, 0, 0), "after_right_wall");
    for (int k = 1; k <= 150; k++) tick(1'b1, mk(604 - 4 * k, 48, 1, 0, 0), "walk_left");
    tick(1'b1, mk(0, 64, 1, 0, 0), "left_wall");
    for (int k = 1; k <= 25; k++) tick(1'b1, mk(4 * k, 64, 1, 0, 0), "walk_row3");

    // Hit coinciding with a frame tick at (100,64).
    cyc(1'b0, 1'b1, 1'b1, 1'b1, mk(100, 64, 0, 1, 0), "hit_with_tick");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, mk(100, 64, 0, 0, 0), "kill_one_cycle");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, mk(100, 64, 0, 0, 0), "hit_while_dead");

`ifdef SPIDER_RESPAWN_EN
    for (int k = 1; k <= 59; k++) tick(1'b1, mk(100, 64, 0, 0, 0), "dead_wait");
    tick(1'b1, mk(0, 32, 1, 0, 0), "respawn");
`else
    tick(1'b1, mk(100, 64, 0, 0, 0), "dead_to_idle");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, mk(100, 64, 0, 0, 0), "hit_in_idle2");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, mk(0, 32, 1, 0, 0), "restart");
`endif

    // 26 full rows down to y=448, checking each row end, then the wrap.
    for (int r = 1; r <= 26; r++) begin
      for (int k = 0; k < 151; k++) tick(1'b0, none, "");
      tick(1'b1, mk((r % 2) ? 608 : 0, 32 + 16 * r, 1, 0, 0), "row_end");
    end
    for (int k = 0; k < 151; k++) tick(1'b0, none, "");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, mk(608, 32, 1, 0, 1), "bottom_wrap");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, mk(608, 32, 1, 0, 0), "bottom_one_cycle");
    tick(1'b1, mk(604, 32, 1, 0, 0), "after_wrap");

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 sb.push_back(mk(0, 32, 0, 0, 0));
    compare("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b1, mk(0, 32, 0, 0, 0), "hit_after_reset");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, mk(0, 32, 0, 0, 0), "tick_after_reset");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, mk(0, 32, 1, 0, 0), "start_after_reset");
    tick(1'b1, mk(4, 32, 1, 0, 0), "move_after_reset");

    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spider_controller.md
SPIDER_CONTROLLER -- requirements
Module: spider_controller

Interface
REQ-001 Parameter X_MIN, 0: leftmost sprite left edge, in pixels.
REQ-002 Parameter X_MAX, 608: rightmost sprite left edge (640-32), in pixels.
REQ-003 Parameter Y_START, 32: spawn row for the sprite top edge.
REQ-004 Parameter Y_MAX, 448: lowest allowed sprite top edge.
REQ-005 Parameter STEP_X, 4: horizontal pixels moved per frame.
REQ-006 Parameter STEP_Y, 16: pixels descended per wall bounce.
REQ-007 Parameter RESPAWN_FRAMES, 60: frames spent dead before respawn.
REQ-008 clk  in  1: single system clock; the block SHALL use no other clock.
REQ-009 rst_n  in  1: asynchronous, active-low reset.
REQ-010 start  in  1: one-cycle pulse that starts play from IDLE.
REQ-011 frame_tick  in  1: one-cycle pulse per video frame (vsync start).
REQ-012 hit  in  1: one-cycle pulse from collision logic; the spider was shot.
REQ-013 spider_x  out  10: sprite left edge, feeds the sprite drawer.
REQ-014 spider_y  out  10: sprite top edge, feeds the sprite drawer.
REQ-015 spider_alive  out  1: high while the sprite is to be drawn.
REQ-016 kill_pulse  out  1: one-cycle pulse on each accepted hit (score event).
REQ-017 bottom_pulse  out  1: one-cycle pulse when the spider wraps past Y_MAX.

Function
REQ-018 The FSM SHALL have states IDLE, ALIVE and DEAD; all outputs SHALL be registered.
REQ-019 IDLE -> ALIVE on start: x=X_MIN, y=Y_START, direction=right, spider_alive=1 on the next cycle.
REQ-020 In ALIVE, spider_x and spider_y SHALL change only in the cycle after frame_tick, so that no frame tears.
REQ-021 Moving right: if x+STEP_X >= X_MAX then x=X_MAX, direction=left, descend; otherwise x=x+STEP_X.
REQ-022 Moving left: if x <= X_MIN+STEP_X then x=X_MIN, direction=right, descend; otherwise x=x-STEP_X.
REQ-023 Descend: if y+STEP_Y > Y_MAX then y=Y_START and bottom_pulse=1 for one cycle; otherwise y=y+STEP_Y.
REQ-024 Arithmetic SHALL be 11-bit internally; no output value outside [X_MIN,X_MAX] or [Y_START,Y_MAX] SHALL ever appear.
REQ-025 ALIVE -> DEAD on hit: spider_alive=0 and kill_pulse=1 in the next cycle, position frozen, frame counter cleared.
REQ-026 If hit and frame_tick coincide, the hit SHALL win and no move SHALL occur.
REQ-027 hit in IDLE or DEAD SHALL be ignored, with no kill_pulse; start outside IDLE SHALL be ignored.
REQ-028 In DEAD the frame counter SHALL count frame_tick pulses.
REQ-029 After the RESPAWN_FRAMES-th frame_tick in DEAD, the FSM SHALL enter ALIVE with the position and direction set as in REQ-019.
REQ-030 kill_pulse and bottom_pulse SHALL never be high for more than one consecutive cycle.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, spider_x=X_MIN, spider_y=Y_START, spider_alive=0, kill_pulse=0, bottom_pulse=0, direction=right and frame counter=0, regardless of clk.
REQ-032 A reset during ALIVE or DEAD SHALL abort play; a start is required afterwards.

Configuration
REQ-033 Macro SPIDER_RESPAWN_EN defined: DEAD behaves as in REQ-028 and REQ-029.
REQ-034 Macro SPIDER_RESPAWN_EN undefined: DEAD SHALL return to IDLE on the first frame_tick and wait for start; the frame counter logic SHALL be omitted.

Verification
REQ-035 Reset, then start, then 3 frame_ticks -> alive=1, (x,y)=(12,32); no change between ticks.
REQ-036 With x=604 moving right, one frame_tick -> x=608, direction=left, y=48; the next tick gives x=604.
REQ-037 With y=448 at a wall, one frame_tick -> y=32 and bottom_pulse high for exactly 1 cycle.
REQ-038 hit coinciding with a frame_tick at (100,64) -> alive=0, one kill_pulse, position stays (100,64); a second hit gives no pulse.
REQ-039 With RESPAWN_EN defined, kill then 59 ticks -> still dead; the 60th tick gives alive=1 at (0,32). With it undefined, the first tick gives IDLE.
REQ-040 rst_n asserted mid-ALIVE between clock edges -> outputs reach reset values without a clk edge; hit ignored until start.
